serial_byte_deser: RTL

Upstream feeder for the even/odd classifier. It collects a bit-serial frame of DATA_W data bits, MSB first, followed by an optional parity bit. Each good frame is presented as a parallel word with a one-cycle valid strobe, which drives the classifier's `data_in` / `in_valid` directly. The block also flags parity failures and counts frames aborted by an early start-of-frame.

---
 rtl/serial_byte_deser.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_byte_deser.sv
// Bit-serial frame deserializer: DATA_W data bits MSB first plus optional parity bit.
// Emits good words with a one-cycle valid strobe, flags parity errors, counts aborted frames.
module serial_byte_deser #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_bit_valid,
  input  logic              i_bit_in,
  input  logic              i_sof,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_out_valid,
  output logic              o_parity_err,
  output logic              o_busy,
  output logic [7:0]        o_drop_cnt
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic [7:0]        r_drop;

  logic [DATA_W-1:0] w_shift;
  logic [CntW-1:0]   w_cnt_nxt;
  logic              w_last_data;
  logic              w_par_ok;

  assign w_shift     = {r_shreg[DATA_W-2:0], i_bit_in};
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_last_data = (w_cnt_nxt == CntW'(DATA_W));
  // XOR over data and parity bit must equal the selected parity sense.
  assign w_par_ok    = ((^r_shreg) ^ i_bit_in) == 1'(PARITY_ODD);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_drop  <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      if (i_bit_valid) begin
        if (i_sof) begin
          // A start bit while a frame is open aborts it and begins a new one.
          if (r_state != ST_IDLE && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
          end
          r_shreg <= {{(DATA_W-1){1'b0}}, i_bit_in};
          r_cnt   <= CntW'(1);
          r_state <= ST_SHIFT;
        end else begin
          case (r_state)
            ST_SHIFT: begin
              r_shreg <= w_shift;
              r_cnt   <= w_cnt_nxt;
              if (w_last_data) begin
                if (PARITY_EN != 0) begin
                  r_state <= ST_PAR;
                end else begin
                  r_data  <= w_shift;
                  r_valid <= 1'b1;
                  r_state <= ST_IDLE;
                end
              end
            end
            ST_PAR: begin
              if (w_par_ok) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
              end else begin
                r_perr <= 1'b1;
              end
              r_state <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_data_out   = r_data;
  assign o_out_valid  = r_valid;
  assign o_parity_err = r_perr;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_drop_cnt   = r_drop;

endmodule
